// File: rtl/traffic_light_top.sv
// Three-aspect traffic-light controller (RED -> GREEN -> YELLOW -> RED).
// Each state has its own dwell time, set by a parameter and clamped to 1..255.
// Optional checks are enabled by the macro TRAFFIC_LIGHT_PARAM_CHECK_EN:
//   - elaboration errors for durations outside 1..255
//   - run-time assertions on the state code and lamp one-hotness

module traffic_light_fsm #(
  parameter int RED_CYCLES    = 8,
  parameter int GREEN_CYCLES  = 6,
  parameter int YELLOW_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       red,
  output logic       yellow,
  output logic       green,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    S_RED    = 2'b00,
    S_GREEN  = 2'b01,
    S_YELLOW = 2'b10,
    S_BAD    = 2'b11
  } state_e;

  function automatic logic [7:0] clamp_dur(input int v);
    if (v < 1)        return 8'd1;
    else if (v > 255) return 8'd255;
    else              return v[7:0];
  endfunction

  localparam logic [7:0] RED_D    = clamp_dur(RED_CYCLES);
  localparam logic [7:0] GREEN_D  = clamp_dur(GREEN_CYCLES);
  localparam logic [7:0] YELLOW_D = clamp_dur(YELLOW_CYCLES);

  logic [7:0] count_q, count_d;
  logic [7:0] dur;
  state_e     state_d;

  // Next-state and dwell-counter logic; the illegal code always falls back to RED.
  always_comb begin
    dur     = RED_D;
    state_d = S_RED;
    count_d = 8'd0;
    case (state)
      S_RED:    dur = RED_D;
      S_GREEN:  dur = GREEN_D;
      S_YELLOW: dur = YELLOW_D;
      default:  dur = RED_D;
    endcase
    if (state == S_BAD) begin
      state_d = S_RED;
      count_d = 8'd0;
    end else if (count_q == 8'(dur - 8'd1)) begin
      count_d = 8'd0;
      case (state)
        S_RED:    state_d = S_GREEN;
        S_GREEN:  state_d = S_YELLOW;
        default:  state_d = S_RED;
      endcase
    end else begin
      state_d = state_e'(state);
      count_d = count_q + 8'd1;
    end
  end

  // State and dwell counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_RED;
      count_q <= 8'd0;
    end else begin
      state   <= state_d;
      count_q <= count_d;
    end
  end

  // Moore lamp decode; the illegal code lights nothing.
  assign red    = (state == S_RED);
  assign yellow = (state == S_YELLOW);
  assign green  = (state == S_GREEN);

`ifdef TRAFFIC_LIGHT_PARAM_CHECK_EN
  if (RED_CYCLES < 1 || RED_CYCLES > 255) begin : g_bad_red
    $error("RED_CYCLES out of range 1..255");
  end
  if (GREEN_CYCLES < 1 || GREEN_CYCLES > 255) begin : g_bad_green
    $error("GREEN_CYCLES out of range 1..255");
  end
  if (YELLOW_CYCLES < 1 || YELLOW_CYCLES > 255) begin : g_bad_yellow
    $error("YELLOW_CYCLES out of range 1..255");
  end

  // Flag the illegal code and non-one-hot lamps whenever out of reset.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (state != S_BAD) else $error("illegal state code 2'b11");
      if (state != S_BAD)
        assert ($onehot({red, yellow, green})) else $error("lamps not one-hot");
    end
  end
`endif

endmodule

// Thin wrapper: one controller instance, ports forwarded one-to-one.
module traffic_light_top #(
  parameter int RED_CYCLES    = 8,
  parameter int GREEN_CYCLES  = 6,
  parameter int YELLOW_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       red,
  output logic       yellow,
  output logic       green,
  output logic [1:0] state
);

  traffic_light_fsm #(
    .RED_CYCLES   (RED_CYCLES),
    .GREEN_CYCLES (GREEN_CYCLES),
    .YELLOW_CYCLES(YELLOW_CYCLES)
  ) u_fsm (
    .clk   (clk),
    .rst_n (rst_n),
    .red   (red),
    .yellow(yellow),
    .green (green),
    .state (state)
  );

endmodule

// File: tb/tb_traffic_light_top.sv
// Directed bench for traffic_light_top: default-duration DUT plus a 1/1/1 DUT.
module tb_traffic_light_top;

  logic       clk = 1'b0;
  logic       rst_n, rst1_n;
  logic       red, yellow, green;
  logic [1:0] state;
  logic       red1, yellow1, green1;
  logic [1:0] state1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  traffic_light_top dut (
    .clk(clk), .rst_n(rst_n),
    .red(red), .yellow(yellow), .green(green), .state(state)
  );

  traffic_light_top #(.RED_CYCLES(1), .GREEN_CYCLES(1), .YELLOW_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst1_n),
    .red(red1), .yellow(yellow1), .green(green1), .state(state1)
  );

  typedef struct {
    logic       rst_n;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  // Expected {state, R, Y, G} for a state code.
  function automatic logic [4:0] exp_of(input logic [1:0] s);
    case (s)
      2'b00:   return 5'b00_100;
      2'b01:   return 5'b01_001;
      2'b10:   return 5'b10_010;
      default: return 5'b11_000;
    endcase
  endfunction

  // Expected state k edges after release with 8/6/2 dwells.
  function automatic logic [1:0] dflt_phase(input int k);
    int t;
    t = k % 16;
    if (t < 8)       return 2'b00;
    else if (t < 14) return 2'b01;
    else             return 2'b10;
  endfunction

  task automatic chk(input string nm, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got {st,R,Y,G}=%b want %b", nm, got, exp);
    end
  endtask

  // Drive resets at negedge, return 1 time unit after the following posedge.
  task automatic step(input logic r, input logic r1);
    @(negedge clk);
    rst_n  = r;
    rst1_n = r1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    rst1_n = 1'b0;

    // 3 reset cycles then 60 free-running cycles
    for (int i = 0; i < 3; i++) vecs.push_back('{1'b0, 2'b00});
    for (int k = 1; k <= 60; k++) vecs.push_back('{1'b1, dflt_phase(k)});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, 1'b0);
      chk($sformatf("seq[%0d]", i), {state, red, yellow, green}, exp_of(vecs[i].st));
    end

    // Reset pulse during GREEN at count 3 restarts a full RED dwell
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int k = 1; k <= 11; k++) step(1'b1, 1'b0);
    chk("green_cnt3", {state, red, yellow, green}, exp_of(2'b01));
    step(1'b0, 1'b0);
    chk("midreset", {state, red, yellow, green}, exp_of(2'b00));
    for (int k = 1; k <= 7; k++) begin
      step(1'b1, 1'b0);
      chk($sformatf("red_after_rst[%0d]", k), {state, red, yellow, green}, exp_of(2'b00));
    end
    step(1'b1, 1'b0);
    chk("green_after_rst", {state, red, yellow, green}, exp_of(2'b01));

    // 1/1/1 durations: state changes every edge
    step(1'b1, 1'b0);
    chk("d1_reset", {state1, red1, yellow1, green1}, exp_of(2'b00));
    for (int k = 1; k <= 9; k++) begin
      logic [1:0] e;
      step(1'b1, 1'b1);
      e = (k % 3 == 0) ? 2'b00 : (k % 3 == 1) ? 2'b01 : 2'b10;
      chk($sformatf("d1[%0d]", k), {state1, red1, yellow1, green1}, exp_of(e));
    end

    // Illegal code: lamps dark, next edge returns to RED
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    @(negedge clk);
    force dut.u_fsm.state = 2'b11;
    #1;
    chk("illegal_lamps", {state, red, yellow, green}, exp_of(2'b11));
    #1;
    release dut.u_fsm.state;
    @(posedge clk);
    #1;
    chk("illegal_recover", {state, red, yellow, green}, exp_of(2'b00));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
